// File: rtl/uart_result_serializer.sv
// uart_result_serializer
// Buffers result words in a small FIFO and frames them for a byte-wide UART
// transmitter: SYNC_BYTE header, word bytes LSB-first, optional XOR checksum.
// Optional feature macro: UART_SER_CHECKSUM_EN (appends a checksum byte).
// Each byte is handed over with a one-cycle tx_valid, then the block waits for
// tx_ready to go low and high again before the next byte is prepared.
module uart_result_serializer #(
  parameter int         WORD_W     = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int BYTES = WORD_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef UART_SER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_BYTE    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_WAIT_HI = 3'd6,
    ST_CSUM    = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_BYTE    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_WAIT_HI = 3'd6
  } state_t;
`endif

  // What kind of byte is currently in flight; decides what follows it.
  typedef enum logic [1:0] {
    K_HDR  = 2'd0,
    K_DATA = 2'd1,
    K_CSUM = 2'd2
  } kind_t;

  // FIFO storage and bookkeeping
  logic [WORD_W:0]     mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                push_s;
  logic                pop_s;
  logic                fifo_nempty_s;

  // FSM and datapath state
  state_t              state_r, state_s;
  kind_t               kind_r, kind_s;
  logic [7:0]          tx_data_r, tx_data_s;
  logic [WORD_W-1:0]   word_r, word_s;
  logic                last_r, last_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                in_pkt_r, in_pkt_s;
  logic                tx_valid_s;
`ifdef UART_SER_CHECKSUM_EN
  logic [7:0]          csum_r, csum_s;
`endif

  assign word_ready    = (count_r != FULL_CNT);
  assign push_s        = word_valid && word_ready;
  assign fifo_nempty_s = (count_r != {CNT_W{1'b0}});

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_s;
  assign busy     = (state_r != ST_IDLE) || fifo_nempty_s;

  // FIFO payload write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {word_last, word_in};
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next-state and datapath decode for the framing FSM.
  always_comb begin
    state_s    = state_r;
    kind_s     = kind_r;
    tx_data_s  = tx_data_r;
    word_s     = word_r;
    last_s     = last_r;
    idx_s      = idx_r;
    in_pkt_s   = in_pkt_r;
    pop_s      = 1'b0;
    tx_valid_s = 1'b0;
`ifdef UART_SER_CHECKSUM_EN
    csum_s     = csum_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (fifo_nempty_s) begin
          state_s = in_pkt_r ? ST_LOAD : ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        tx_data_s = SYNC_BYTE;
        kind_s    = K_HDR;
        in_pkt_s  = 1'b1;
`ifdef UART_SER_CHECKSUM_EN
        csum_s    = 8'h00;
`endif
        state_s   = ST_SEND;
      end
      ST_LOAD: begin
        pop_s            = 1'b1;
        {last_s, word_s} = mem_r[rd_ptr_r];
        idx_s            = {IDX_W{1'b0}};
        state_s          = ST_BYTE;
      end
      ST_BYTE: begin
        tx_data_s = 8'(word_r >> {idx_r, 3'b000});
        kind_s    = K_DATA;
        state_s   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_s = 1'b1;
          state_s    = ST_WAIT_LO;
        end else begin
          state_s    = ST_SEND;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_ready) begin
          state_s = ST_WAIT_HI;
        end else begin
          state_s = ST_WAIT_LO;
        end
      end
      ST_WAIT_HI: begin
        if (tx_ready) begin
          if (kind_r == K_HDR) begin
            state_s = fifo_nempty_s ? ST_LOAD : ST_IDLE;
          end else if (kind_r == K_DATA) begin
`ifdef UART_SER_CHECKSUM_EN
            csum_s = csum_r ^ tx_data_r;
`endif
            if (idx_r != LAST_IDX) begin
              idx_s   = idx_r + IDX_W'(1);
              state_s = ST_BYTE;
            end else if (!last_r) begin
              state_s = fifo_nempty_s ? ST_LOAD : ST_IDLE;
            end else begin
`ifdef UART_SER_CHECKSUM_EN
              state_s  = ST_CSUM;
`else
              state_s  = ST_IDLE;
              in_pkt_s = 1'b0;
`endif
            end
          end else begin
            // checksum byte finished: packet closed
            state_s  = ST_IDLE;
            in_pkt_s = 1'b0;
          end
        end else begin
          state_s = ST_WAIT_HI;
        end
      end
`ifdef UART_SER_CHECKSUM_EN
      ST_CSUM: begin
        tx_data_s = csum_r;
        kind_s    = K_CSUM;
        state_s   = ST_SEND;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers; reset aborts any packet in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      kind_r    <= K_HDR;
      tx_data_r <= 8'h00;
      word_r    <= {WORD_W{1'b0}};
      last_r    <= 1'b0;
      idx_r     <= {IDX_W{1'b0}};
      in_pkt_r  <= 1'b0;
`ifdef UART_SER_CHECKSUM_EN
      csum_r    <= 8'h00;
`endif
    end else begin
      state_r   <= state_s;
      kind_r    <= kind_s;
      tx_data_r <= tx_data_s;
      word_r    <= word_s;
      last_r    <= last_s;
      idx_r     <= idx_s;
      in_pkt_r  <= in_pkt_s;
`ifdef UART_SER_CHECKSUM_EN
      csum_r    <= csum_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_result_serializer.sv
// Directed bench for uart_result_serializer with a scoreboard of expected
// transmitter bytes and a simple transmitter model driving tx_ready.
module tb_uart_result_serializer;

  logic        clk;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  logic        rdy_m = 1'b1;
  logic        hold  = 1'b0;
  assign tx_ready = rdy_m && !hold;

  int          total  = 0;
  int          bad    = 0;
  int          pulses = 0;
  int          dbl    = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        pkt_open = 1'b0;
  logic [7:0]  csum_m   = 8'h00;

  uart_result_serializer #(
    .WORD_W(32),
    .FIFO_DEPTH(4),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_last(word_last),
    .word_ready(word_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: records each valid byte, drops ready one cycle later,
  // raises it again 10 cycles after that.
  initial begin : xmit_model
    int cnt;
    bit drop;
    bit prev_v;
    cnt = 0;
    drop = 1'b0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        drop = 1'b0;
        prev_v = 1'b0;
        rdy_m = 1'b1;
      end else begin
        if (tx_valid) begin
          got_q.push_back(tx_data);
          pulses++;
          if (prev_v) dbl++;
        end
        if (drop) begin
          rdy_m = 1'b0;
          cnt = 10;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) rdy_m = 1'b1;
        end
        drop = tx_valid;
        prev_v = tx_valid;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word (called at a negedge) and record the bytes it must produce.
  task automatic push(input logic [31:0] w, input logic l);
    int n = 0;
    if (!pkt_open) begin
      exp_q.push_back(8'hA5);
      csum_m = 8'h00;
      pkt_open = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(w[8*b +: 8]);
      csum_m = csum_m ^ w[8*b +: 8];
    end
    if (l) begin
`ifdef UART_SER_CHECKSUM_EN
      exp_q.push_back(csum_m);
`endif
      pkt_open = 1'b0;
    end
    word_in = w;
    word_last = l;
    word_valid = 1'b1;
    while (!word_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 32'(word_ready), 32'd1);
    @(negedge clk);
    word_valid = 1'b0;
    word_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Compare every byte the model captured against the scoreboard.
  task automatic drain(input string tag, input bit need_empty);
    logic [7:0] g;
    logic [7:0] e;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_byte"}, 32'(g), 32'(e));
      end else begin
        chk({tag, "_extra_byte"}, 32'(g), 32'h100);
      end
    end
    if (need_empty) chk({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int p0;
    int n;
    rst = 1'b1;
    word_in = 32'h0;
    word_valid = 1'b0;
    word_last = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_word_ready", 32'(word_ready), 32'd1);

    // single-word packet
    p0 = pulses;
    push(32'h11223344, 1'b1);
    wait_idle("t1");
    drain("t1", 1'b1);
`ifdef UART_SER_CHECKSUM_EN
    chk("t1_pulses", 32'(pulses - p0), 32'd6);
`else
    chk("t1_pulses", 32'(pulses - p0), 32'd5);
`endif
    chk("t1_double_valid", 32'(dbl), 32'd0);

    // two-word packet, one header
    push(32'h01020304, 1'b0);
    push(32'h0A0B0C0D, 1'b1);
    wait_idle("t2");
    drain("t2", 1'b1);

    // FIFO fills while the transmitter is held busy
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'h10203040 + 32'(i) * 32'h01010101, 1'b0);
    end
    chk("t3_full_ready", 32'(word_ready), 32'd0);
    chk("t3_hold_valid", 32'(tx_valid), 32'd0);
    chk("t3_hold_data", 32'(tx_data), 32'hA5);
    repeat (5) @(negedge clk);
    chk("t3_hold_valid2", 32'(tx_valid), 32'd0);
    chk("t3_hold_data2", 32'(tx_data), 32'hA5);
    @(posedge clk);
    #1 hold = 1'b0;
    @(negedge clk);
    chk("t3_valid_on_ready", 32'(tx_valid), 32'd1);
    push(32'hA1B2C3D4, 1'b0);
    push(32'hE5F60718, 1'b1);
    wait_idle("t3");
    drain("t3", 1'b1);
    chk("t3_double_valid", 32'(dbl), 32'd0);

    // input gap inside a packet: no second header
    push(32'hDEADBEEF, 1'b0);
    wait_idle("t4a");
    repeat (50) @(negedge clk);
    push(32'h55AA33CC, 1'b1);
    wait_idle("t4");
    drain("t4", 1'b1);

    // reset during the second data byte
    p0 = pulses;
    push(32'hCAFEBABE, 1'b1);
    n = 0;
    while ((pulses - p0) < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_byte1", 32'(pulses - p0 >= 3), 32'd1);
    rst = 1'b1;
    drain("t5_pre", 1'b0);
    exp_q.delete();
    pkt_open = 1'b0;
    repeat (2) @(negedge clk);
    got_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_tx_valid", 32'(tx_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_word_ready", 32'(word_ready), 32'd1);
    push(32'h0BADF00D, 1'b1);
    wait_idle("t5");
    drain("t5", 1'b1);
    chk("t5_double_valid", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
